// File: rtl/lbp_image_server_if.sv
// Gray-read / LBP-write / readback bundle between the LBP engine shell and the image server.
// Latency: none of its own; it only carries wires.
// Backpressure: ld_ready throttles the load stream; every other channel is strobe-only.
//
// Ports (by direction from the server's side, modport slave):
//   in : ld_valid, ld_data, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish, rd_addr
//   out: ld_ready, gray_ready, gray_data, done, wr_count, err, rd_data
interface lbp_image_server_if #(
  parameter int AW = 14,
  parameter int DW = 8
);
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic          gray_ready;
  logic [DW-1:0] gray_data;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [DW-1:0] lbp_data;
  logic          finish;
  logic          done;
  logic [AW-1:0] wr_count;
  logic          err;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  // Engine / host side.
  modport master (
    output ld_valid, ld_data, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data,
           finish, rd_addr,
    input  ld_ready, gray_ready, gray_data, done, wr_count, err, rd_data
  );

  // Image server side.
  modport slave (
    input  ld_valid, ld_data, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data,
           finish, rd_addr,
    output ld_ready, gray_ready, gray_data, done, wr_count, err, rd_data
  );
endinterface

// File: rtl/lbp_image_server.sv
// Image server for the LBP engine: loads a 128x128 gray image, serves reads, captures and checks results.
// Latency: gray_data is same-cycle combinational; rd_data is 1 cycle after rd_addr (DONE only).
// Backpressure: ld_ready gates the load stream; lbp writes and gray reads are never stalled.
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - lbp_image_server_if.slave (load stream, gray read, lbp write, status, readback)
module lbp_image_server #(
  parameter int AW   = 14,
  parameter int DW   = 8,
  parameter int NPIX = 1 << AW
) (
  input  logic                clk,
  input  logic                reset,
  lbp_image_server_if.slave   bus
);

  localparam int HW = AW / 2;  // bits per coordinate

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SERVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        state_q;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] wr_count_q, wr_count_d;
  logic          ld_ready_q;
  logic          gray_ready_q;
  logic          done_q;
  logic          err_q;
  logic [DW-1:0] rd_data_q;

  logic          ld_acc;
  logic          last_byte;
  logic          serve_wr;
  logic          lbp_border;
  logic          err_set;
  logic [HW-1:0] lbp_x, lbp_y;

  // Memories are deliberately not reset; the load pass initialises both.
  logic [DW-1:0] gray_mem [NPIX];
  logic [DW-1:0] lbp_mem  [NPIX];

  always_comb begin
    ld_acc     = (state_q == S_LOAD) && bus.ld_valid && ld_ready_q;
    last_byte  = ld_acc && (idx_q == AW'(NPIX - 1));
    idx_d      = last_byte ? '0 : idx_q + 1'b1;
    serve_wr   = (state_q == S_SERVE) && bus.lbp_valid;
    lbp_x      = bus.lbp_addr[HW-1:0];
    lbp_y      = bus.lbp_addr[AW-1:HW];
    lbp_border = (lbp_x == '0) || (lbp_x == '1) || (lbp_y == '0) || (lbp_y == '1);
    wr_count_d = (&wr_count_q) ? wr_count_q : wr_count_q + 1'b1;
    // Protocol violations: result writes outside SERVE, any engine activity
    // before the image is loaded, and result writes onto the border ring.
    err_set    = (bus.lbp_valid && (state_q != S_SERVE))
               || ((state_q == S_LOAD) && (bus.gray_req || bus.finish))
               || (serve_wr && lbp_border);
  end

  always_ff @(posedge clk) begin
    if (ld_acc) begin
      gray_mem[idx_q] <= bus.ld_data;
    end
  end

  // The load pass clears the result map so untouched border pixels read back 0.
  always_ff @(posedge clk) begin
    if (ld_acc) begin
      lbp_mem[idx_q] <= '0;
    end else if (serve_wr) begin
      lbp_mem[bus.lbp_addr] <= bus.lbp_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_LOAD;
      idx_q        <= '0;
      ld_ready_q   <= 1'b0;
      gray_ready_q <= 1'b0;
      done_q       <= 1'b0;
      wr_count_q   <= '0;
      err_q        <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      if (err_set) begin
        err_q <= 1'b1;
      end
      case (state_q)
        S_LOAD: begin
          ld_ready_q <= 1'b1;
          if (ld_acc) begin
            idx_q <= idx_d;
          end
          if (last_byte) begin
            ld_ready_q   <= 1'b0;
            gray_ready_q <= 1'b1;
            state_q      <= S_SERVE;
          end
        end
        S_SERVE: begin
          // A write coinciding with finish is still counted before leaving.
          if (serve_wr) begin
            wr_count_q <= wr_count_d;
          end
          if (bus.finish) begin
            gray_ready_q <= 1'b0;
            done_q       <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        S_DONE: begin
          rd_data_q <= lbp_mem[bus.rd_addr];
        end
        default: begin
          state_q <= S_LOAD;
        end
      endcase
    end
  end

  assign bus.gray_data  = ((state_q == S_SERVE) && bus.gray_req) ? gray_mem[bus.gray_addr] : '0;
  assign bus.ld_ready   = ld_ready_q;
  assign bus.gray_ready = gray_ready_q;
  assign bus.done       = done_q;
  assign bus.wr_count   = wr_count_q;
  assign bus.err        = err_q;
  assign bus.rd_data    = rd_data_q;

endmodule

// File: tb/tb_lbp_image_server.sv
// Directed bench for lbp_image_server: table-driven SERVE vectors plus hand sequences.
// Latency: checks gray_data at the falling edge, registered outputs 1 time unit after the rising edge.
// Backpressure: load bytes wait (bounded) on ld_ready.
module tb_lbp_image_server;

  localparam int AW   = 14;
  localparam int NPIX = 16384;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  lbp_image_server_if bus ();

  lbp_image_server dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          gray_req;
    logic [AW-1:0] gray_addr;
    logic          lbp_valid;
    logic [AW-1:0] lbp_addr;
    logic [7:0]    lbp_data;
    logic [7:0]    exp_gray;
    logic          exp_err;
    logic [AW-1:0] exp_wc;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] img_b [NPIX];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one byte after 'gap' idle cycles; the byte is accepted on the
  // first rising edge with ld_ready high. Caller is at posedge+1.
  task automatic load_byte(input logic [7:0] d, input int gap);
    int n;
    repeat (gap) tick();
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    n = 0;
    while (!bus.ld_ready && n < 16) begin
      tick();
      n++;
    end
    if (n == 16) begin
      checks++;
      failures++;
      $display("FAIL ld_ready_timeout actual=0 expected=1");
    end
    tick();
    bus.ld_valid = 1'b0;
  endtask

  // Last byte of an image: gray_ready must rise exactly one cycle later.
  task automatic load_last(input logic [7:0] d, input int gap);
    repeat (gap) tick();
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    @(negedge clk);
    chk("gray_ready_before_last", bus.gray_ready, 1'b0);
    chk("ld_ready_before_last", bus.ld_ready, 1'b1);
    tick();
    bus.ld_valid = 1'b0;
    chk("gray_ready_after_last", bus.gray_ready, 1'b1);
    chk("ld_ready_after_last", bus.ld_ready, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ld_ready"},   bus.ld_ready,   1'b0);
    chk({tag, "_gray_ready"}, bus.gray_ready, 1'b0);
    chk({tag, "_done"},       bus.done,       1'b0);
    chk({tag, "_wr_count"},   bus.wr_count,   0);
    chk({tag, "_err"},        bus.err,        1'b0);
    chk({tag, "_rd_data"},    bus.rd_data,    0);
  endtask

  // Golden LBP code from the bench's own image copy: neighbours clockwise
  // from top-left, bit k set when neighbour k >= centre.
  function automatic logic [7:0] lbp_of(input int x, input int y);
    int dx [8] = '{-1, 0, 1, 1, 1, 0, -1, -1};
    int dy [8] = '{-1, -1, -1, 0, 1, 1, 1, 0};
    logic [7:0] c, code;
    c    = img_b[y * 128 + x];
    code = '0;
    for (int k = 0; k < 8; k++) begin
      code[k] = (img_b[(y + dy[k]) * 128 + (x + dx[k])] >= c);
    end
    return code;
  endfunction

  initial begin
    int rows [5] = '{0, 1, 64, 126, 127};

    checks   = 0;
    failures = 0;
    // {req, gaddr, lv, laddr, ldata, exp_gray, exp_err, exp_wc}; image A is pixel[i]=i[7:0]
    vecs[0] = '{1'b1, 14'h0081, 1'b0, 14'h0000, 8'h00, 8'h81, 1'b0, 14'd0};
    vecs[1] = '{1'b0, 14'h0005, 1'b0, 14'h0000, 8'h00, 8'h00, 1'b0, 14'd0};
    vecs[2] = '{1'b1, 14'h3FFF, 1'b0, 14'h0000, 8'h00, 8'hFF, 1'b0, 14'd0};
    vecs[3] = '{1'b1, 14'h1234, 1'b1, 14'h0081, 8'hA5, 8'h34, 1'b0, 14'd1};
    vecs[4] = '{1'b0, 14'h0000, 1'b1, 14'h0102, 8'h11, 8'h00, 1'b0, 14'd2};
    vecs[5] = '{1'b1, 14'h0000, 1'b1, 14'h007F, 8'h77, 8'h00, 1'b1, 14'd3};
    vecs[6] = '{1'b1, 14'h0080, 1'b1, 14'h0182, 8'h22, 8'h80, 1'b1, 14'd4};
    vecs[7] = '{1'b0, 14'h0000, 1'b0, 14'h0000, 8'h00, 8'h00, 1'b1, 14'd4};

    bus.ld_valid  = 1'b0;
    bus.ld_data   = '0;
    bus.gray_req  = 1'b0;
    bus.gray_addr = '0;
    bus.lbp_valid = 1'b0;
    bus.lbp_addr  = '0;
    bus.lbp_data  = '0;
    bus.finish    = 1'b0;
    bus.rd_addr   = '0;
    reset         = 1'b0;

    // ---- Reset state and ld_ready release ----
    #1;
    check_reset_outputs("por");
    repeat (3) tick();
    reset = 1'b1;
    chk("ld_ready_at_release", bus.ld_ready, 1'b0);
    tick();
    chk("ld_ready_first_cycle", bus.ld_ready, 1'b1);

    // ---- Run A: image pixel[i]=i[7:0], one byte every third cycle ----
    for (int i = 0; i < NPIX - 1; i++) load_byte(8'(i), 2);
    load_last(8'hFF, 2);

    bus.rd_addr = 14'h0081;
    foreach (vecs[i]) begin
      bus.gray_req  = vecs[i].gray_req;
      bus.gray_addr = vecs[i].gray_addr;
      bus.lbp_valid = vecs[i].lbp_valid;
      bus.lbp_addr  = vecs[i].lbp_addr;
      bus.lbp_data  = vecs[i].lbp_data;
      @(negedge clk);
      chk($sformatf("vec%0d_gray_data", i), bus.gray_data, vecs[i].exp_gray);
      tick();
      chk($sformatf("vec%0d_err", i), bus.err, vecs[i].exp_err);
      chk($sformatf("vec%0d_wr_count", i), bus.wr_count, vecs[i].exp_wc);
    end
    chk("serve_rd_data_zero", bus.rd_data, 0);
    chk("serve_gray_ready", bus.gray_ready, 1'b1);
    chk("serve_done", bus.done, 1'b0);

    // finish and a write in the same cycle: write lands, counted, then DONE
    bus.finish    = 1'b1;
    bus.lbp_valid = 1'b1;
    bus.lbp_addr  = 14'h3EFE;
    bus.lbp_data  = 8'h3C;
    @(negedge clk);
    chk("done_before_finish_edge", bus.done, 1'b0);
    tick();
    bus.finish    = 1'b0;
    bus.lbp_valid = 1'b0;
    chk("done_after_finish", bus.done, 1'b1);
    chk("wr_count_finish_write", bus.wr_count, 5);
    chk("gray_ready_in_done", bus.gray_ready, 1'b0);
    chk("ld_ready_in_done", bus.ld_ready, 1'b0);

    bus.rd_addr = 14'h0081; tick(); chk("rd_0081", bus.rd_data, 8'hA5);
    bus.rd_addr = 14'h0000; tick(); chk("rd_0000", bus.rd_data, 8'h00);
    bus.rd_addr = 14'h3EFE; tick(); chk("rd_3EFE", bus.rd_data, 8'h3C);
    bus.rd_addr = 14'h007F; tick(); chk("rd_007F_border_written", bus.rd_data, 8'h77);
    bus.gray_req  = 1'b1;
    bus.gray_addr = 14'h0081;
    @(negedge clk);
    chk("gray_data_in_done", bus.gray_data, 8'h00);
    tick();
    bus.gray_req = 1'b0;

    // ---- Run B: reset, partial load, LOAD-phase errors, reset mid-load ----
    reset = 1'b0;
    #1;
    reset = 1'b1;
    tick();
    for (int i = 0; i < 5000; i++) load_byte(8'(~i), 0);
    bus.lbp_valid = 1'b1;
    bus.lbp_addr  = 14'h0102;
    bus.lbp_data  = 8'h99;
    tick();
    bus.lbp_valid = 1'b0;
    chk("lbp_valid_in_load_err", bus.err, 1'b1);
    chk("lbp_valid_in_load_wc", bus.wr_count, 0);
    chk("still_loading_ld_ready", bus.ld_ready, 1'b1);

    reset = 1'b0;
    #1;
    check_reset_outputs("midload");
    chk("midload_gray_data", bus.gray_data, 0);
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) load_byte(8'(i), 0);
    bus.gray_req  = 1'b1;
    bus.gray_addr = 14'h0000;
    @(negedge clk);
    chk("gray_req_in_load_data", bus.gray_data, 0);
    tick();
    bus.gray_req = 1'b0;
    chk("gray_req_in_load_err", bus.err, 1'b1);
    reset = 1'b0;
    #1;
    reset = 1'b1;
    tick();

    // ---- Full reload with a random image ----
    for (int i = 0; i < NPIX; i++) img_b[i] = 8'($urandom);
    img_b[0] = 8'hC3;
    for (int i = 0; i < NPIX - 1; i++) load_byte(img_b[i], 0);
    load_last(img_b[NPIX-1], 0);
    chk("reload_err_clear", bus.err, 1'b0);

    bus.gray_req  = 1'b1;
    bus.gray_addr = 14'h0000;
    @(negedge clk);
    chk("reload_gray_0", bus.gray_data, 8'hC3);
    tick();
    bus.gray_addr = 14'h2A55;
    @(negedge clk);
    chk("reload_gray_2A55", bus.gray_data, img_b[14'h2A55]);
    tick();
    bus.gray_req = 1'b0;

    // Engine-like pass: one result per interior pixel.
    for (int y = 1; y < 127; y++) begin
      for (int x = 1; x < 127; x++) begin
        bus.lbp_valid = 1'b1;
        bus.lbp_addr  = 14'(y * 128 + x);
        bus.lbp_data  = lbp_of(x, y);
        tick();
      end
    end
    bus.lbp_valid = 1'b0;
    chk("clean_wr_count", bus.wr_count, 15876);
    chk("clean_err", bus.err, 1'b0);

    // Drive the counter into saturation with harmless rewrites.
    bus.lbp_valid = 1'b1;
    bus.lbp_addr  = 14'h0081;
    bus.lbp_data  = lbp_of(1, 1);
    repeat (507) tick();
    chk("wr_count_all_ones", bus.wr_count, 14'h3FFF);
    tick();
    bus.lbp_valid = 1'b0;
    chk("wr_count_saturated", bus.wr_count, 14'h3FFF);

    bus.finish = 1'b1;
    tick();
    bus.finish = 1'b0;
    chk("run_b_done", bus.done, 1'b1);

    foreach (rows[r]) begin
      for (int x = 0; x < 128; x++) begin
        logic [7:0] exp;
        exp = (rows[r] == 0 || rows[r] == 127 || x == 0 || x == 127) ? 8'h00 : lbp_of(x, rows[r]);
        bus.rd_addr = 14'(rows[r] * 128 + x);
        tick();
        chk($sformatf("readback_y%0d_x%0d", rows[r], x), bus.rd_data, exp);
      end
    end

    bus.lbp_valid = 1'b1;
    bus.lbp_addr  = 14'h0102;
    bus.lbp_data  = 8'h5A;
    tick();
    bus.lbp_valid = 1'b0;
    chk("lbp_valid_in_done_err", bus.err, 1'b1);
    chk("lbp_valid_in_done_wc", bus.wr_count, 14'h3FFF);
    bus.rd_addr = 14'h0102;
    tick();
    tick();
    chk("lbp_valid_in_done_no_write", bus.rd_data, lbp_of(2, 2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
